// File: rtl/placement_cost_eval.sv
// Wirelength evaluator: walks an external edge list, fetches both endpoint
// positions, and accumulates Manhattan cost, hop cost, max span and the
// unplaced/overlap edge counts. One edge takes 8 cycles (RD_E..ACC).
//
// Handshake: start is a one-cycle request honoured only in IDLE; busy is
// high from the cycle after acceptance until the DONE cycle; done pulses
// for one cycle when results are final. Memory reads: a strobe (e_re/p_re)
// in cycle t returns data from cycle t+1, held until the next strobe.
module placement_cost_eval #(
  parameter int GRID_N  = 11,
  parameter int DATA_W  = 32,
  parameter int EADDR_W = 8,
  parameter int PADDR_W = 7,
  parameter int SUM_W   = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [EADDR_W:0]   num_edges,
  input  logic [1:0]         hop_sel,
  output logic               busy,
  output logic               done,
  output logic               e_re,
  output logic [EADDR_W-1:0] e_addr,
  input  logic [DATA_W-1:0]  e_a,
  input  logic [DATA_W-1:0]  e_b,
  output logic               p_re,
  output logic [PADDR_W-1:0] p_addr,
  input  logic [DATA_W-1:0]  p_x,
  input  logic [DATA_W-1:0]  p_y,
  output logic [SUM_W-1:0]   sum_cost,
  output logic [SUM_W-1:0]   sum_hop,
  output logic [DATA_W-1:0]  max_span,
  output logic [EADDR_W:0]   unplaced_cnt,
  output logic [EADDR_W:0]   overlap_cnt
);

  localparam logic [3:0] IDLE = 4'd0;
  localparam logic [3:0] RD_E = 4'd1;
  localparam logic [3:0] WT_E = 4'd2;
  localparam logic [3:0] RD_A = 4'd3;
  localparam logic [3:0] WT_A = 4'd4;
  localparam logic [3:0] RD_B = 4'd5;
  localparam logic [3:0] WT_B = 4'd6;
  localparam logic [3:0] CALC = 4'd7;
  localparam logic [3:0] ACC  = 4'd8;
  localparam logic [3:0] DONE = 4'd9;

  localparam int IW = DATA_W + 2;
  localparam int AW = ((SUM_W > IW) ? SUM_W : IW) + 1;
  localparam logic [DATA_W-1:0] GRID_LIM = DATA_W'(GRID_N);
  localparam logic [DATA_W-1:0] D_ONE    = {{(DATA_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W:0]   S_ONE    = {{DATA_W{1'b0}}, 1'b1};
  localparam logic [IW-1:0]     H_ONE    = {{(IW-1){1'b0}}, 1'b1};
  localparam logic [EADDR_W:0]  CNT_ONE  = {{EADDR_W{1'b0}}, 1'b1};
  localparam logic [AW-1:0]     SAT_LIM  = {{(AW-SUM_W){1'b0}}, {SUM_W{1'b1}}};

  logic [3:0]         state;
  logic [EADDR_W:0]   i;
  logic [EADDR_W:0]   n_lat;
  logic [1:0]         hop_lat;
  logic [PADDR_W-1:0] b;
  logic [DATA_W-1:0]  ax, ay;
  logic [DATA_W-1:0]  dx, dy;
  logic [DATA_W:0]    hx, hy;
  logic               invalid;

  logic [EADDR_W:0]   i_inc;
  logic [DATA_W-1:0]  diff_x, diff_y, dx_c, dy_c;
  logic [DATA_W:0]    hop_mask, hx_c, hy_c;
  logic               invalid_c;
  logic [DATA_W:0]    span, cost_inc;
  logic [IW-1:0]      hop_inc;
  logic [AW-1:0]      cost_tmp, hop_tmp;
  logic [SUM_W-1:0]   cost_sat, hop_sat;
  logic               unused_bits;

  // Endpoint a is used straight from the edge port during RD_A; only the
  // low PADDR_W bits of a node id address the position memory.
  assign unused_bits = ^{e_a[DATA_W-1:PADDR_W], e_b[DATA_W-1:PADDR_W]};

  function automatic logic off_grid(input logic [DATA_W-1:0] c);
    return c[DATA_W-1] || (c >= GRID_LIM);
  endfunction

  assign busy   = (state != IDLE) && (state != DONE);
  assign done   = (state == DONE);
  assign e_re   = (state == RD_E);
  assign p_re   = (state == RD_A) || (state == RD_B);
  assign e_addr = i[EADDR_W-1:0];
  assign i_inc  = i + CNT_ONE;

  // Position read address: endpoint a live from the edge port, then stored b.
  always_comb begin
    p_addr = '0;
    if (state == RD_A)      p_addr = e_a[PADDR_W-1:0];
    else if (state == RD_B) p_addr = b;
  end

  // Per-edge geometry from (ax,ay) and the held (bx,by) = (p_x,p_y).
  always_comb begin
    diff_x    = ax - p_x;
    diff_y    = ay - p_y;
    dx_c      = diff_x[DATA_W-1] ? (~diff_x) + D_ONE : diff_x;
    dy_c      = diff_y[DATA_W-1] ? (~diff_y) + D_ONE : diff_y;
    invalid_c = off_grid(ax) || off_grid(ay) || off_grid(p_x) || off_grid(p_y);
    hop_mask  = '0;
    case (hop_lat)
      2'd0:    hop_mask[2:0] = 3'b000;
      2'd1:    hop_mask[2:0] = 3'b001;
      2'd2:    hop_mask[2:0] = 3'b011;
      default: hop_mask[2:0] = 3'b111;
    endcase
    hx_c = ({1'b0, dx_c} + hop_mask) >> hop_lat;
    hy_c = ({1'b0, dy_c} + hop_mask) >> hop_lat;
  end

  // Saturating accumulation of the registered edge costs.
  always_comb begin
    span     = {1'b0, dx} + {1'b0, dy};
    cost_inc = span - S_ONE;
    hop_inc  = {1'b0, hx} + {1'b0, hy} - H_ONE;
    cost_tmp = AW'(sum_cost) + AW'(cost_inc);
    hop_tmp  = AW'(sum_hop) + AW'(hop_inc);
    cost_sat = (cost_tmp > SAT_LIM) ? {SUM_W{1'b1}} : cost_tmp[SUM_W-1:0];
    hop_sat  = (hop_tmp > SAT_LIM) ? {SUM_W{1'b1}} : hop_tmp[SUM_W-1:0];
  end

  // Sequencer and result registers; async reset aborts any run silently.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      i            <= '0;
      n_lat        <= '0;
      hop_lat      <= '0;
      b            <= '0;
      ax           <= '0;
      ay           <= '0;
      dx           <= '0;
      dy           <= '0;
      hx           <= '0;
      hy           <= '0;
      invalid      <= 1'b0;
      sum_cost     <= '0;
      sum_hop      <= '0;
      max_span     <= '0;
      unplaced_cnt <= '0;
      overlap_cnt  <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          n_lat        <= num_edges;
          hop_lat      <= hop_sel;
          i            <= '0;
          sum_cost     <= '0;
          sum_hop      <= '0;
          max_span     <= '0;
          unplaced_cnt <= '0;
          overlap_cnt  <= '0;
          state        <= (num_edges == '0) ? DONE : RD_E;
        end
        RD_E: state <= WT_E;
        WT_E: state <= RD_A;
        RD_A: begin
          b     <= e_b[PADDR_W-1:0];
          state <= WT_A;
        end
        WT_A: state <= RD_B;
        RD_B: begin
          ax    <= p_x;
          ay    <= p_y;
          state <= WT_B;
        end
        WT_B: state <= CALC;
        CALC: begin
          invalid <= invalid_c;
          dx      <= dx_c;
          dy      <= dy_c;
          hx      <= hx_c;
          hy      <= hy_c;
          state   <= ACC;
        end
        ACC: begin
          if (invalid) begin
            unplaced_cnt <= unplaced_cnt + CNT_ONE;
          end else if ((dx == '0) && (dy == '0)) begin
            overlap_cnt <= overlap_cnt + CNT_ONE;
          end else begin
            sum_cost <= cost_sat;
            sum_hop  <= hop_sat;
            if (span > {1'b0, max_span}) max_span <= span[DATA_W-1:0];
          end
          i     <= i_inc;
          state <= (i_inc == n_lat) ? DONE : RD_E;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_placement_cost_eval.sv
// Directed bench for placement_cost_eval (SUM_W=8 build so saturation is
// reachable). A behavioural model computes expected results from the memory
// contents; a per-cycle compare process checks timing, strobes and results.
module tb_placement_cost_eval;

  localparam int GRID_N  = 11;
  localparam int DATA_W  = 32;
  localparam int EADDR_W = 8;
  localparam int PADDR_W = 7;
  localparam int SUM_W   = 8;
  localparam longint SUM_MAX = (64'd1 << SUM_W) - 1;

  logic               clk;
  logic               reset;
  logic               start;
  logic [EADDR_W:0]   num_edges;
  logic [1:0]         hop_sel;
  logic               busy, done, e_re, p_re;
  logic [EADDR_W-1:0] e_addr;
  logic [PADDR_W-1:0] p_addr;
  logic [DATA_W-1:0]  e_a, e_b, p_x, p_y;
  logic [SUM_W-1:0]   sum_cost, sum_hop;
  logic [DATA_W-1:0]  max_span;
  logic [EADDR_W:0]   unplaced_cnt, overlap_cnt;

  logic [DATA_W-1:0] ea_mem [256];
  logic [DATA_W-1:0] eb_mem [256];
  logic [DATA_W-1:0] px_mem [128];
  logic [DATA_W-1:0] py_mem [128];

  int     tests = 0;
  int     fails = 0;
  int     cyc = 0;
  bit     active = 0;
  int     start_cyc = 0;
  int     exp_done = 0;
  int     n_run = 0;
  int     last_done_cyc = -1;
  longint exp_cost = 0, exp_hop = 0, exp_span = 0, exp_unp = 0, exp_ovl = 0;

  placement_cost_eval #(
    .GRID_N(GRID_N), .DATA_W(DATA_W), .EADDR_W(EADDR_W),
    .PADDR_W(PADDR_W), .SUM_W(SUM_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .num_edges(num_edges),
    .hop_sel(hop_sel), .busy(busy), .done(done), .e_re(e_re),
    .e_addr(e_addr), .e_a(e_a), .e_b(e_b), .p_re(p_re), .p_addr(p_addr),
    .p_x(p_x), .p_y(p_y), .sum_cost(sum_cost), .sum_hop(sum_hop),
    .max_span(max_span), .unplaced_cnt(unplaced_cnt), .overlap_cnt(overlap_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // external read-only memories: data appears the cycle after the strobe
  always @(posedge clk) begin
    if (e_re) begin
      e_a <= ea_mem[e_addr];
      e_b <= eb_mem[e_addr];
    end
    if (p_re) begin
      p_x <= px_mem[p_addr];
      p_y <= py_mem[p_addr];
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_edge(input int k, input int a, input int b);
    ea_mem[k] = DATA_W'(a);
    eb_mem[k] = DATA_W'(b);
  endtask

  task automatic set_pos(input int node, input int x, input int y);
    px_mem[node] = DATA_W'(x);
    py_mem[node] = DATA_W'(y);
  endtask

  function automatic bit off(input longint c);
    return (c < 0) || (c >= GRID_N);
  endfunction

  // behavioural model: the results the evaluation must produce
  task automatic model(input int n, input int hop);
    longint ax, ay, bx, by, dx, dy, s;
    int a, b;
    exp_cost = 0; exp_hop = 0; exp_span = 0; exp_unp = 0; exp_ovl = 0;
    s = longint'(1) << hop;
    for (int k = 0; k < n; k++) begin
      a  = int'(ea_mem[k]) % 128;
      b  = int'(eb_mem[k]) % 128;
      ax = longint'($signed(px_mem[a]));
      ay = longint'($signed(py_mem[a]));
      bx = longint'($signed(px_mem[b]));
      by = longint'($signed(py_mem[b]));
      if (off(ax) || off(ay) || off(bx) || off(by)) begin
        exp_unp++;
      end else begin
        dx = (ax > bx) ? ax - bx : bx - ax;
        dy = (ay > by) ? ay - by : by - ay;
        if (dx == 0 && dy == 0) begin
          exp_ovl++;
        end else begin
          exp_cost = exp_cost + dx + dy - 1;
          if (exp_cost > SUM_MAX) exp_cost = SUM_MAX;
          exp_hop = exp_hop + (dx + s - 1) / s + (dy + s - 1) / s - 1;
          if (exp_hop > SUM_MAX) exp_hop = SUM_MAX;
          if (dx + dy > exp_span) exp_span = dx + dy;
        end
      end
    end
  endtask

  task automatic chk_results(input string tag);
    chk({tag, "_cost"}, longint'(sum_cost), exp_cost);
    chk({tag, "_hop"}, longint'(sum_hop), exp_hop);
    chk({tag, "_span"}, longint'(max_span), exp_span);
    chk({tag, "_unplaced"}, longint'(unplaced_cnt), exp_unp);
    chk({tag, "_overlap"}, longint'(overlap_cnt), exp_ovl);
  endtask

  // scoreboard: timing, strobe exclusivity, cleared/final/held results
  always @(negedge clk) begin
    if (reset) begin
      if (done) last_done_cyc = cyc;
      chk("strobe_excl", longint'(e_re && p_re), 0);
      if (active && cyc >= start_cyc) begin
        if (cyc == start_cyc && n_run > 0) begin
          chk("clr_cost", longint'(sum_cost), 0);
          chk("clr_unplaced", longint'(unplaced_cnt), 0);
        end
        if (cyc < exp_done) begin
          chk("busy_run", longint'(busy), 1);
          chk("done_early", longint'(done), 0);
        end else begin
          chk("done_pulse", longint'(done), 1);
          chk("busy_done", longint'(busy), 0);
          chk_results("final");
          active = 0;
        end
      end else if (!active) begin
        chk("done_idle", longint'(done), 0);
        chk("busy_idle", longint'(busy), 0);
        chk_results("hold");
      end
    end
  end

  task automatic launch(input int n, input int hop);
    @(posedge clk); #2;
    model(n, hop);
    n_run     = n;
    start_cyc = cyc + 1;
    exp_done  = start_cyc + 8 * n;
    active    = 1;
    start     = 1'b1;
    num_edges = (EADDR_W+1)'(n);
    hop_sel   = 2'(hop);
    @(posedge clk); #2;
    start     = 1'b0;
    num_edges = (EADDR_W+1)'(n + 3);
    hop_sel   = 2'(hop) ^ 2'b01;
  endtask

  task automatic run_eval(input int n, input int hop, input bit extra_start);
    launch(n, hop);
    if (extra_start) begin
      repeat (3) @(posedge clk);
      #2 start = 1'b1;
      @(posedge clk);
      #2 start = 1'b0;
    end
    for (int k = 0; k < 8 * n + 20 && active; k++) @(posedge clk);
    if (active) begin
      chk("timeout", 1, 0);
      active = 0;
    end
    repeat (2) @(posedge clk);
    #2;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, longint'(busy), 0);
    chk({tag, "_done"}, longint'(done), 0);
    chk({tag, "_e_re"}, longint'(e_re), 0);
    chk({tag, "_p_re"}, longint'(p_re), 0);
    chk({tag, "_e_addr"}, longint'(e_addr), 0);
    chk({tag, "_p_addr"}, longint'(p_addr), 0);
    chk({tag, "_cost"}, longint'(sum_cost), 0);
    chk({tag, "_hop"}, longint'(sum_hop), 0);
    chk({tag, "_span"}, longint'(max_span), 0);
    chk({tag, "_unplaced"}, longint'(unplaced_cnt), 0);
    chk({tag, "_overlap"}, longint'(overlap_cnt), 0);
  endtask

  task automatic load_three_edges();
    set_edge(0, 0, 1);
    set_edge(1, 1, 2);
    set_edge(2, 3, 4);
    set_pos(2, -1, -1);
    set_pos(3, 4, 4);
    set_pos(4, 4, 4);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // directed stimulus
  initial begin
    for (int k = 0; k < 256; k++) set_edge(k, 0, 0);
    for (int k = 0; k < 128; k++) set_pos(k, 0, 0);
    reset = 1'b0; start = 1'b0; num_edges = '0; hop_sel = '0;
    repeat (3) @(posedge clk);
    #1 chk_all_zero("reset");
    #1 reset = 1'b1;

    // one edge (0,0)-(3,5)
    set_edge(0, 0, 1);
    set_pos(0, 0, 0);
    set_pos(1, 3, 5);
    run_eval(1, 1, 0);
    chk("t1_cost_lit", longint'(sum_cost), 7);
    chk("t1_hop_lit", longint'(sum_hop), 4);
    chk("t1_span_lit", longint'(max_span), 8);
    chk("t1_latency", longint'(last_done_cyc - (start_cyc - 1)), 9);
    run_eval(1, 2, 0);
    chk("t2_hop4_lit", longint'(sum_hop), 2);
    run_eval(1, 0, 0);
    chk("t2_hop1_lit", longint'(sum_hop), 7);
    chk("t2_cost_lit", longint'(sum_cost), 7);

    // unplaced and overlapping edges leave the sums alone
    load_three_edges();
    run_eval(3, 1, 0);
    chk("t3_unp_lit", longint'(unplaced_cnt), 1);
    chk("t3_ovl_lit", longint'(overlap_cnt), 1);
    chk("t3_cost_lit", longint'(sum_cost), 7);
    chk("t3_hop_lit", longint'(sum_hop), 4);

    // zero edges, then a start pulse while busy
    run_eval(0, 1, 0);
    chk("t4_zero_latency", longint'(last_done_cyc - (start_cyc - 1)), 1);
    chk("t4_zero_cost", longint'(sum_cost), 0);
    run_eval(3, 1, 1);
    chk("t4_busy_start_latency", longint'(last_done_cyc - (start_cyc - 1)), 25);

    // saturation: 14 span-20 edges, 19 each
    for (int k = 0; k < 14; k++) set_edge(k, 5, 6);
    set_pos(5, 0, 0);
    set_pos(6, 10, 10);
    run_eval(14, 1, 0);
    chk("t5_cost_sat_lit", longint'(sum_cost), 255);
    chk("t5_hop_lit", longint'(sum_hop), 126);
    chk("t5_span_lit", longint'(max_span), 20);

    // reversed edge, off-grid coordinate, hop step 8
    set_edge(0, 1, 0);
    set_edge(1, 7, 8);
    set_edge(2, 8, 9);
    set_pos(7, 11, 2);
    set_pos(8, 2, 2);
    set_pos(9, 9, 0);
    run_eval(3, 3, 0);
    chk("t6_cost_lit", longint'(sum_cost), 15);
    chk("t6_hop_lit", longint'(sum_hop), 2);
    chk("t6_span_lit", longint'(max_span), 9);
    chk("t6_unp_lit", longint'(unplaced_cnt), 1);

    // reset during WT_A of the second edge, then a clean rerun
    load_three_edges();
    launch(3, 1);
    while (cyc < start_cyc + 11) begin
      @(posedge clk);
      #1;
    end
    #1;
    active = 0;
    reset  = 1'b0;
    #1 chk_all_zero("abort");
    exp_cost = 0; exp_hop = 0; exp_span = 0; exp_unp = 0; exp_ovl = 0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    repeat (12) @(posedge clk);
    #2;
    run_eval(3, 1, 0);
    chk("t7_cost_lit", longint'(sum_cost), 7);
    chk("t7_unp_lit", longint'(unplaced_cnt), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
